// File: rtl/palabras_four_tx.sv
// palabras_four_tx
// Serializes one word of palabras_escale bytes toward a UART TX core.
// Each byte goes out on one transmitter handshake.
//
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   rst        asynchronous active-low reset
//   data_in    word to send; sampled only on acceptance
//   data_valid request to send data_in
//   ready      high when a word can be accepted (IDLE only)
//   tx_done    one-cycle pulse from the UART core when the current byte has finished
//   dato_tx    byte presented to the UART core; held stable between tx_start pulses
//   tx_start   one-cycle pulse; the UART core latches dato_tx
//   flat_sent  one-cycle pulse one cycle after the last byte's tx_done
//   busy       high from acceptance through the flat_sent cycle
//
// Handshake: a word is accepted on a rising edge where data_valid=1 and
// ready=1. data_valid while ready=0 is dropped; it is not queued.
// Toward the UART core, tx_start hands over one byte. tx_done is honoured
// only in WAIT, and at most once per WAIT visit.
//
// Build option: define PALABRAS_MSB_FIRST_EN to send the most-significant
// byte first. By default the least-significant byte goes first.
// All outputs are registered, so each one reflects the current FSM state.

module palabras_four_tx #(
  parameter int palabras_escale = 8,
  parameter int bits_escale     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [palabras_escale*8-1:0] data_in,
  input  logic                         data_valid,
  output logic                         ready,
  input  logic                         tx_done,
  output logic [7:0]                   dato_tx,
  output logic                         tx_start,
  output logic                         flat_sent,
  output logic                         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [bits_escale-1:0] LAST_CON = bits_escale'(palabras_escale - 1);

  state_t                       state, state_n;
  logic [bits_escale-1:0]       con, con_n;
  logic [palabras_escale*8-1:0] hold, hold_n;
  logic [7:0]                   dato_n;
  logic                         tx_start_n, flat_n, busy_n, ready_n;

  // Byte-select path. On acceptance, the first byte comes straight from
  // data_in, because the hold register is loaded on that same edge.
  logic                         load_byte;
  logic [bits_escale-1:0]       sel_con;
  logic [bits_escale-1:0]       byte_idx;
  logic [palabras_escale*8-1:0] src_word;

  always_comb begin
    state_n    = state;
    con_n      = con;
    hold_n     = hold;
    dato_n     = dato_tx;
    tx_start_n = 1'b0;
    flat_n     = 1'b0;
    busy_n     = busy;
    ready_n    = ready;
    load_byte  = 1'b0;
    sel_con    = con;
    src_word   = hold;
    byte_idx   = '0;

    case (state)
      IDLE: begin
        if (data_valid) begin
          hold_n     = data_in;
          con_n      = '0;
          sel_con    = '0;
          src_word   = data_in;
          load_byte  = 1'b1;
          tx_start_n = 1'b1;
          busy_n     = 1'b1;
          ready_n    = 1'b0;
          state_n    = SEND;
        end
      end
      SEND: begin
        // tx_done is ignored here; the core has only just been started.
        state_n = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (con == LAST_CON) begin
            flat_n  = 1'b1;
            state_n = DONE;
          end else begin
            con_n      = con + 1'b1;
            sel_con    = con + 1'b1;
            load_byte  = 1'b1;
            tx_start_n = 1'b1;
            state_n    = SEND;
          end
        end
      end
      DONE: begin
        // The hold register keeps the last word; only the counter rewinds.
        con_n   = '0;
        busy_n  = 1'b0;
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

`ifdef PALABRAS_MSB_FIRST_EN
    byte_idx = LAST_CON - sel_con;
`else
    byte_idx = sel_con;
`endif

    if (load_byte) begin
      dato_n = src_word[{byte_idx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      con       <= '0;
      hold      <= '0;
      dato_tx   <= 8'h00;
      tx_start  <= 1'b0;
      flat_sent <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b1;
    end else begin
      state     <= state_n;
      con       <= con_n;
      hold      <= hold_n;
      dato_tx   <= dato_n;
      tx_start  <= tx_start_n;
      flat_sent <= flat_n;
      busy      <= busy_n;
      ready     <= ready_n;
    end
  end

endmodule

// File: tb/tb_palabras_four_tx.sv
// Bench for palabras_four_tx.
// A UART responder answers each tx_start with a tx_done pulse 10 cycles later.
// The bench predicts the byte stream from each accepted word.
// Each tx_start is then checked against the head of that prediction.

module tb_palabras_four_tx;

  localparam int PE = 8;
  localparam int W  = PE * 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         ready;
  logic         tx_done;
  logic [7:0]   dato_tx;
  logic         tx_start;
  logic         flat_sent;
  logic         busy;

  logic         uart_done;
  logic         inj_done;
  int           uart_cnt;

  assign tx_done = uart_done | inj_done;

  palabras_four_tx #(.palabras_escale(PE), .bits_escale(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .tx_done    (tx_done),
    .dato_tx    (dato_tx),
    .tx_start   (tx_start),
    .flat_sent  (flat_sent),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int flat_cnt  = 0;
  int cyc       = 0;
  int last_start_cyc = 0;
  int last_gap  = 0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // UART responder: tx_done is high in the 10th cycle after the tx_start cycle.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      uart_cnt  = 0;
      uart_done = 1'b0;
    end else if (tx_start) begin
      uart_cnt  = 10;
      uart_done = 1'b0;
    end else if (uart_cnt > 0) begin
      uart_cnt  = uart_cnt - 1;
      uart_done = (uart_cnt == 0);
    end else begin
      uart_done = 1'b0;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      start_cnt++;
      last_gap       = cyc - last_start_cyc;
      last_start_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_tx_start", 1, 0);
      end else begin
        check("dato_tx", W'(dato_tx), W'(exp_q.pop_front()));
      end
      check("busy_in_send", W'(busy), 1);
    end
    if (flat_sent) begin
      flat_cnt++;
      check("flat_after_txdone", W'(prev_done), 1);
      check("ready_in_done", W'(ready), 0);
      check("busy_in_done", W'(busy), 1);
    end
    prev_done = tx_done;
  end

  // driver tasks
  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < PE; i++) begin
`ifdef PALABRAS_MSB_FIRST_EN
      exp_q.push_back(d[8*(PE-1-i) +: 8]);
`else
      exp_q.push_back(d[8*i +: 8]);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit hold_valid);
    int guard = 0;
    @(negedge clk); #1;
    while (!ready && guard < 500) begin
      @(negedge clk); #1;
      guard++;
    end
    check("ready_wait_timeout", W'(ready), 1);
    data_in    = d;
    data_valid = 1'b1;
    push_word(d);
    tick();
    if (!hold_valid) data_valid = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    int guard = 0;
    @(negedge clk); #1;
    while (start_cnt < target && guard < 500) begin
      @(negedge clk); #1;
      guard++;
    end
    check("tx_start_timeout", W'(start_cnt >= target), 1);
  endtask

  // Returns in the flat_sent cycle of the next completed word.
  task automatic wait_flat(input int target);
    int guard = 0;
    @(negedge clk); #1;
    while (flat_cnt < target && guard < 1000) begin
      @(negedge clk); #1;
      guard++;
    end
    check("flat_sent_timeout", W'(flat_cnt >= target), 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int base_s, base_f;

  initial begin
    rst        = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    inj_done   = 1'b0;
    uart_done  = 1'b0;
    uart_cnt   = 0;
    #1 rst = 1'b0;
    idle_cycles(3);
    check("rst_ready",     W'(ready),     1);
    check("rst_busy",      W'(busy),      0);
    check("rst_tx_start",  W'(tx_start),  0);
    check("rst_flat_sent", W'(flat_sent), 0);
    check("rst_dato_tx",   W'(dato_tx),   0);
    @(negedge clk) rst = 1'b1;

    // Basic word.
    base_s = start_cnt; base_f = flat_cnt;
    send_word(64'h8877_6655_4433_2211, 1'b0);
    check("first_start_latency", W'(tx_start), 1);
    wait_flat(base_f + 1);
    check("w1_starts", W'(start_cnt - base_s), 8);
    @(negedge clk); #1;
    check("w1_ready_after_flat", W'(ready), 1);
    check("w1_busy_after_flat",  W'(busy), 0);
    check("w1_flat_one_cycle",   W'(flat_sent), 0);
    check("w1_flat_count",       W'(flat_cnt - base_f), 1);

    // data_valid during the 3rd byte is ignored.
    base_s = start_cnt; base_f = flat_cnt;
    send_word(64'h1234_5678_9ABC_DEF0, 1'b0);
    wait_starts(base_s + 3);
    idle_cycles(2);
    data_in    = 64'hFFFF_FFFF_FFFF_FFFF;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    wait_flat(base_f + 1);
    idle_cycles(20);
    check("ign_starts", W'(start_cnt - base_s), 8);
    check("ign_flats",  W'(flat_cnt - base_f), 1);
    check("ign_queue_empty", W'(exp_q.size()), 0);

    // tx_done in the SEND cycle, then held high for 3 cycles in WAIT.
    base_s = start_cnt; base_f = flat_cnt;
    send_word(64'hA1B2_C3D4_E5F6_0718, 1'b0);
    inj_done = 1'b1;   // SEND cycle of byte 1
    tick();
    inj_done = 1'b0;
    wait_starts(base_s + 2);
    check("send_txdone_ignored_gap", W'(last_gap), 11);
    idle_cycles(3);
    inj_done = 1'b1;
    idle_cycles(3);
    inj_done = 1'b0;
    wait_flat(base_f + 1);
    idle_cycles(20);
    check("hold_starts", W'(start_cnt - base_s), 8);
    check("hold_queue_empty", W'(exp_q.size()), 0);

    // Reset in WAIT after byte 4.
    base_s = start_cnt;
    send_word(64'h0F1E_2D3C_4B5A_6978, 1'b0);
    wait_starts(base_s + 4);
    idle_cycles(3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_ready",    W'(ready),     1);
    check("async_rst_busy",     W'(busy),      0);
    check("async_rst_tx_start", W'(tx_start),  0);
    check("async_rst_dato_tx",  W'(dato_tx),   0);
    check("async_rst_flat",     W'(flat_sent), 0);
    exp_q.delete();
    base_s = start_cnt;
    idle_cycles(4);
    @(negedge clk) rst = 1'b1;
    idle_cycles(20);
    check("rst_no_more_starts", W'(start_cnt - base_s), 0);
    base_f = flat_cnt;
    send_word(64'h0102_0304_0506_0708, 1'b0);
    wait_flat(base_f + 1);
    check("post_rst_starts", W'(start_cnt - base_s), 8);

    // Back-to-back with data_valid held high.
    idle_cycles(2);
    base_s = start_cnt; base_f = flat_cnt;
    send_word(64'h1111_2222_3333_4444, 1'b1);
    data_in = 64'h5555_6666_7777_8888;
    push_word(data_in);
    wait_flat(base_f + 1);
    @(negedge clk); #1;
    check("b2b_ready_idle", W'(ready), 1);
    @(negedge clk); #1;
    check("b2b_immediate_accept", W'(tx_start), 1);
    data_valid = 1'b0;
    wait_flat(base_f + 2);
    idle_cycles(20);
    check("b2b_starts", W'(start_cnt - base_s), 16);
    check("b2b_flats",  W'(flat_cnt - base_f), 2);
    check("final_queue_empty", W'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
